// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter/sequencer.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_t;

  localparam int unsigned WAIT_CYC_DEF = 1;
  localparam int unsigned CNT_W        = 3;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-input round-robin grant picker; the port not granted last wins a tie.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_dbg,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req_cpu | req_dbg;
    gnt_id    = PORT_CPU;
    if (req_cpu && req_dbg) begin
      gnt_id = (last_grant == PORT_DBG) ? PORT_CPU : PORT_DBG;
    end else if (req_dbg) begin
      gnt_id = PORT_DBG;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates CPU and debug word accesses onto the shared asynchronous SRAM and
// sequences its active-low strobes through SETUP / ACCESS / DONE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              busy,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_DQ_out,
  output logic              Mem_DQ_oe,
  input  logic [DATA_W-1:0] Mem_DQ_in
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

  arb_state_t        state, state_nx;
  port_id_t          last_gnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rr_valid;
  logic              rr_id;
  logic              active;

  sram_arb_rr u_rr (
    .req_cpu    (cpu_req),
    .req_dbg    (dbg_req),
    .last_grant (last_gnt),
    .gnt_valid  (rr_valid),
    .gnt_id     (rr_id)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rr_valid) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (cnt_q == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // last_gnt doubles as the owner of the access in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      last_gnt  <= PORT_DBG;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (rr_valid) begin
            last_gnt <= port_id_t'(rr_id);
            if (rr_id == PORT_DBG) begin
              we_q    <= dbg_we;
              addr_q  <= dbg_addr;
              wdata_q <= dbg_wdata;
            end else begin
              we_q    <= cpu_we;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
            end
          end
        end
        SETUP: cnt_q <= WAIT_LD;
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!we_q) begin
            if (last_gnt == PORT_DBG) dbg_rdata <= Mem_DQ_in;
            else                      cpu_rdata <= Mem_DQ_in;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from registered state only, so reset releases them at once
  always_comb begin
    active     = (state != IDLE);
    busy       = active;
    Mem_CE     = ~active;
    Mem_UB     = ~active;
    Mem_LB     = ~active;
    Mem_OE     = ~(active && !we_q);
    Mem_WE     = ~((state == ACCESS) && we_q);
    Mem_DQ_oe  = active && we_q;
    Mem_ADDR   = addr_q;
    Mem_DQ_out = wdata_q;
    cpu_ack    = (state == DONE) && (last_gnt == PORT_CPU);
    dbg_ack    = (state == DONE) && (last_gnt == PORT_DBG);
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level model of
// round-robin order, access latency and memory contents.
module tb_sram_arbiter;

  localparam int W  = 1;
  localparam int W3 = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [19:0] cpu_addr = '0, dbg_addr = '0;
  logic [15:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        cpu_ack, dbg_ack, busy;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_DQ_oe;
  logic [19:0] Mem_ADDR;
  logic [15:0] Mem_DQ_out, Mem_DQ_in;

  logic        cpu_req_3 = 0, cpu_we_3 = 0, dbg_req_3 = 0, dbg_we_3 = 0;
  logic [19:0] cpu_addr_3 = '0, dbg_addr_3 = '0;
  logic [15:0] cpu_wdata_3 = '0, dbg_wdata_3 = '0;
  logic [15:0] cpu_rdata_3, dbg_rdata_3;
  logic        cpu_ack_3, dbg_ack_3, busy_3;
  logic        Mem_CE_3, Mem_UB_3, Mem_LB_3, Mem_OE_3, Mem_WE_3, Mem_DQ_oe_3;
  logic [19:0] Mem_ADDR_3;
  logic [15:0] Mem_DQ_out_3, Mem_DQ_in_3;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .busy(busy), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_ADDR(Mem_ADDR),
    .Mem_DQ_out(Mem_DQ_out), .Mem_DQ_oe(Mem_DQ_oe), .Mem_DQ_in(Mem_DQ_in)
  );

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W3)) dut3 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
    .cpu_rdata(cpu_rdata_3), .cpu_ack(cpu_ack_3),
    .dbg_req(dbg_req_3), .dbg_we(dbg_we_3), .dbg_addr(dbg_addr_3), .dbg_wdata(dbg_wdata_3),
    .dbg_rdata(dbg_rdata_3), .dbg_ack(dbg_ack_3),
    .busy(busy_3), .Mem_CE(Mem_CE_3), .Mem_UB(Mem_UB_3), .Mem_LB(Mem_LB_3),
    .Mem_OE(Mem_OE_3), .Mem_WE(Mem_WE_3), .Mem_ADDR(Mem_ADDR_3),
    .Mem_DQ_out(Mem_DQ_out_3), .Mem_DQ_oe(Mem_DQ_oe_3), .Mem_DQ_in(Mem_DQ_in_3)
  );

  // Behavioural asynchronous SRAMs (256 words visible)
  logic [15:0] sram  [256];
  logic [15:0] sram3 [256];
  logic        pl_en = 0, pl3_en = 0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge Clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (!Mem_CE && !Mem_WE) sram[Mem_ADDR[7:0]] <= Mem_DQ_out;
    if (pl3_en) sram3[pl_addr] <= pl_data;
    else if (!Mem_CE_3 && !Mem_WE_3) sram3[Mem_ADDR_3[7:0]] <= Mem_DQ_out_3;
  end

  assign Mem_DQ_in   = (!Mem_CE && !Mem_OE && Mem_ADDR[19:8] == '0) ? sram[Mem_ADDR[7:0]] : 16'hDEAD;
  assign Mem_DQ_in_3 = (!Mem_CE_3 && !Mem_OE_3 && Mem_ADDR_3[19:8] == '0) ? sram3[Mem_ADDR_3[7:0]] : 16'hDEAD;

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [15:0] ref_mem [256];
  bit          last_dbg = 1'b1;
  logic [15:0] exp_rd_cpu = '0, exp_rd_dbg = '0;
  int          exp_acks = 0;
  int unsigned oe_mask;
  int          we_low;

  // Protocol monitor: strobe exclusivity, DQ/WE ordering, ack count
  int   viol = 0, ack_cnt = 0;
  logic prev_oe = 0, prev_we = 1, prev_rst = 0;
  always @(negedge Clk) begin
    if (!Mem_OE && !Mem_WE) viol++;
    if (!Mem_OE_3 && !Mem_WE_3) viol++;
    if (Mem_DQ_oe && !prev_oe && !Mem_WE) viol++;
    if (!Mem_DQ_oe && prev_oe && Reset && prev_rst && (!Mem_WE || !prev_we)) viol++;
    if (Mem_UB != Mem_CE || Mem_LB != Mem_CE || busy == Mem_CE) viol++;
    if (Mem_UB_3 != Mem_CE_3 || Mem_LB_3 != Mem_CE_3 || busy_3 == Mem_CE_3 || Mem_DQ_oe_3) viol++;
    ack_cnt += int'(cpu_ack) + int'(dbg_ack);
    prev_oe  = Mem_DQ_oe;
    prev_we  = Mem_WE;
    prev_rst = Reset;
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d, input bit third);
    @(negedge Clk);
    pl_addr = a; pl_data = d; pl_en = !third; pl3_en = third;
    @(negedge Clk);
    pl_en = 0; pl3_en = 0;
  endtask

  task automatic model_port(input bit dbg, input bit we, input logic [7:0] a, input logic [15:0] d);
    if (we) ref_mem[a] = d;
    else if (dbg) exp_rd_dbg = ref_mem[a];
    else exp_rd_cpu = ref_mem[a];
    last_dbg = dbg;
    exp_acks++;
  endtask

  task automatic check_reset_vals(input string pre);
    check_eq({pre, "_strobes"}, {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_DQ_oe, cpu_ack, dbg_ack, busy},
             9'b111110000);
    check_eq({pre, "_addr"}, Mem_ADDR, 0);
    check_eq({pre, "_dq_out"}, Mem_DQ_out, 0);
    check_eq({pre, "_rdata"}, {cpu_rdata, dbg_rdata}, 0);
  endtask

  // One round: each selected port issues one request (held until its ack); starts and ends in IDLE
  task automatic run_round(input bit rc, input bit rd, input bit wc, input bit wd,
                           input logic [7:0] ac, input logic [7:0] ad,
                           input logic [15:0] dc, input logic [15:0] dd);
    int unsigned t_c, t_d, got_c, got_d, tt;
    bit dbg_first;
    tt = 3 + W;
    t_c = 0; t_d = 0;
    dbg_first = rd && (!rc || !last_dbg);
    if (dbg_first) begin
      t_d = tt; model_port(1'b1, wd, ad, dd);
      if (rc) begin t_c = 2 * tt + 1; model_port(1'b0, wc, ac, dc); end
    end else begin
      if (rc) begin t_c = tt; model_port(1'b0, wc, ac, dc); end
      if (rd) begin t_d = 2 * tt + 1; model_port(1'b1, wd, ad, dd); end
    end
    cpu_req = rc; cpu_we = wc; cpu_addr = {12'h0, ac}; cpu_wdata = dc;
    dbg_req = rd; dbg_we = wd; dbg_addr = {12'h0, ad}; dbg_wdata = dd;
    oe_mask = Mem_OE ? 0 : 1;
    we_low = 0; got_c = 0; got_d = 0;
    for (int k = 1; k <= 40 && ((rc && got_c == 0) || (rd && got_d == 0)); k++) begin
      @(posedge Clk); @(negedge Clk);
      if (!Mem_OE && k < 32) oe_mask |= (32'd1 << k);
      if (!Mem_WE) we_low++;
      if (cpu_ack) begin got_c = k; cpu_req = 0; end
      if (dbg_ack) begin got_d = k; dbg_req = 0; end
    end
    cpu_req = 0; dbg_req = 0;
    check_eq("cpu_ack_cycle", got_c, t_c);
    check_eq("dbg_ack_cycle", got_d, t_d);
    check_eq("cpu_rdata", cpu_rdata, exp_rd_cpu);
    check_eq("dbg_rdata", dbg_rdata, exp_rd_dbg);
    @(posedge Clk); @(negedge Clk);
  endtask

  initial begin
    int unsigned got, seq, n, k3;
    logic [15:0] d;

    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      ref_mem[i] = d;
      preload(8'(i), d, 1'b0);
    end
    ref_mem[8'h40] = 16'h1234;
    preload(8'h40, 16'h1234, 1'b0);
    preload(8'h2A, 16'hA5A5, 1'b1);
    @(negedge Clk);
    check_reset_vals("reset");
    Reset = 1;
    @(negedge Clk);

    // CPU read with OE profile
    run_round(1, 0, 0, 0, 8'h40, 8'h00, 16'h0, 16'h0);
    check_eq("read_oe_profile", oe_mask, 32'b11110);
    check_eq("read_value", cpu_rdata, 16'h1234);

    // CPU write then readback
    run_round(1, 0, 1, 0, 8'h10, 8'h00, 16'hBEEF, 16'h0);
    check_eq("write_we_low_cycles", we_low, W + 1);
    check_eq("rdata_kept_on_write", cpu_rdata, 16'h1234);
    run_round(1, 0, 0, 0, 8'h10, 8'h00, 16'h0, 16'h0);
    check_eq("readback", cpu_rdata, 16'hBEEF);

    // Request dropped during SETUP still completes
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00040;
    model_port(1'b0, 1'b0, 8'h40, 16'h0);
    got = 0;
    for (int k = 1; k <= 20 && got == 0; k++) begin
      @(posedge Clk); @(negedge Clk);
      if (k == 1) cpu_req = 0;
      if (cpu_ack) got = k;
    end
    check_eq("dropped_req_ack", got, 3 + W);
    check_eq("dropped_req_rdata", cpu_rdata, exp_rd_cpu);
    @(posedge Clk); @(negedge Clk);

    // Longer access on the WAIT_CYC=3 instance
    dbg_req_3 = 1; dbg_addr_3 = 20'h0002A;
    got = 0; k3 = 0;
    for (int k = 1; k <= 30 && got == 0; k++) begin
      @(posedge Clk); @(negedge Clk);
      if (cpu_ack_3) k3++;
      if (dbg_ack_3) begin got = k; dbg_req_3 = 0; end
    end
    check_eq("w3_dbg_ack_cycle", got, 3 + W3);
    check_eq("w3_dbg_rdata", dbg_rdata_3, 16'hA5A5);
    check_eq("w3_no_cpu_ack", {k3, cpu_rdata_3}, 0);
    @(posedge Clk); @(negedge Clk);

    // Randomized mixed traffic
    for (int r = 0; r < 60; r++) begin
      n = $urandom_range(1, 3);
      run_round(n[0], n[1], 1'($urandom), 1'($urandom),
                8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)),
                16'($urandom), 16'($urandom));
    end

    // Reset asserted in the first ACCESS cycle of a write
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h000F0; cpu_wdata = 16'h5A5A;
    repeat (2) begin @(posedge Clk); @(negedge Clk); end
    check_eq("we_low_before_reset", {Mem_WE, Mem_DQ_oe}, 2'b01);
    Reset = 0;
    #1;
    check_eq("reset_release_strobes", {Mem_WE, Mem_DQ_oe, Mem_CE, busy, cpu_ack}, 5'b10100);
    cpu_req = 0;
    repeat (2) @(negedge Clk);
    Reset = 1;
    #1;
    check_reset_vals("post_reset");
    last_dbg = 1; exp_rd_cpu = '0; exp_rd_dbg = '0;
    @(negedge Clk);

    // Tie after reset with both requests held: CPU, DBG, CPU
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00005;
    dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00006;
    seq = 0; n = 0;
    for (int k = 1; k <= 40 && n < 3; k++) begin
      @(posedge Clk); @(negedge Clk);
      if (cpu_ack) begin seq = (seq << 8) | (32'h10 | 32'(k[3:0])); n++; end
      if (dbg_ack) begin seq = (seq << 8) | (32'h20 | 32'(k[3:0])); n++; end
    end
    cpu_req = 0; dbg_req = 0;
    check_eq("tie_sequence", seq, 32'h00_14_29_1E);
    model_port(1'b1, 1'b0, 8'h06, 16'h0);
    model_port(1'b0, 1'b0, 8'h05, 16'h0);
    exp_acks++;
    check_eq("tie_rdata", {cpu_rdata, dbg_rdata}, {ref_mem[8'h05], ref_mem[8'h06]});
    @(posedge Clk); @(negedge Clk);

    run_round(1, 1, 0, 1, 8'h06, 8'h06, 16'h0, 16'hC0DE);

    check_eq("strobe_protocol_violations", viol, 0);
    check_eq("ack_count", ack_cnt, exp_acks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the single asynchronous board SRAM shared by the SLC-3 CPU memory path and a debug/loader port. Accepts word read/write requests from each port, grants one at a time with round-robin fairness, and drives the active-low SRAM strobes with a fixed setup/access/hold sequence. It replaces the direct Mem_OE/Mem_WE driving in the control unit, whose memory states become request/ack waits.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, data width
- WAIT_CYC, 1, extra ACCESS cycles beyond the first (0..7)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU word address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_rdata  out  DATA_W  last CPU read result
- cpu_ack  out  1  one-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same as the cpu_* ports, for the debug port
- busy  out  1  high in any state other than IDLE
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low
- Mem_ADDR  out  ADDR_W  SRAM address
- Mem_DQ_out  out  DATA_W  write data to pad
- Mem_DQ_oe  out  1  pad output enable; the top level builds the tri-state
- Mem_DQ_in  in  DATA_W  read data from pad

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any req is high, pick grant, latch addr/we/wdata, go to SETUP. Otherwise stay.
- Arbitration: round-robin on a last-grant bit.
  - Both requesting: grant the port not granted last.
  - One requesting: grant it.
  - Last-grant resets to DBG, so the CPU wins the first tie.
- SETUP: Mem_ADDR = latched address; CE/UB/LB = 0.
  - Read: OE = 0.
  - Write: Mem_DQ_oe = 1, Mem_DQ_out = wdata, WE = 1.
- ACCESS: WAIT_CYC+1 cycles, counted by a down-counter.
  - Read: OE = 0.
  - Write: WE = 0, DQ driven.
  - Read data is captured from Mem_DQ_in into the granted port's rdata register on the edge that leaves ACCESS.
- DONE: granted port's ack = 1. Strobes and address hold.
  - Read: OE = 0.
  - Write: WE = 1, DQ still driven (hold).
  - Next state is always IDLE.
- rdata registers hold their value until the next read completes on that port. Writes never alter rdata.
- A req that drops mid-access is a protocol violation. The access still completes and ack still pulses.
- A req still high in the IDLE cycle after its ack is treated as a new request.
- Outside SETUP/ACCESS/DONE, all strobes are 1, Mem_DQ_oe = 0, and Mem_ADDR holds its last value.

## Timing
- Reset values: state IDLE; Mem_CE/UB/LB/OE/WE = 1; Mem_DQ_oe = 0; Mem_ADDR = 0; Mem_DQ_out = 0; both rdata = 0; both ack = 0; busy = 0; last-grant = DBG; counter = 0.
- Reset asserted mid-access: strobes go inactive and DQ is released asynchronously. No ack is issued; the requester must reissue.
- Latency: req seen in IDLE at cycle 0 gives ack in cycle 3+WAIT_CYC (4 with the default).
- Throughput: one access per 4+WAIT_CYC cycles.
- Mem_WE is never 0 in the same cycle that Mem_DQ_oe first rises, or in the cycle Mem_DQ_oe falls.
- Mem_OE and Mem_WE are never both 0.
- All outputs are registered or decoded from registered state only; no req-to-strobe combinational path.

## Structure
- Package sram_arb_pkg:
  - state enum (IDLE, SETUP, ACCESS, DONE)
  - port-id typedef (PORT_CPU, PORT_DBG)
  - WAIT_CYC default and counter-width constant
- One sub-module, sram_arb_rr: two-input round-robin grant picker.
  - Inputs: two requests, last-grant bit.
  - Outputs: grant-valid and grant id.
- Sequencer, counter, latches and rdata registers stay in the top module.

## Test plan
- Reset: Reset = 0 mid-write (WAIT_CYC = 1, ACCESS cycle) -> WE = 1, Mem_DQ_oe = 0 immediately, no ack. After release, state IDLE and all reset values hold.
- CPU read: SRAM model holds 0x1234 at 0x00040; cpu_req, cpu_addr = 0x00040 -> OE = 0 for cycles 1–4, cpu_ack in cycle 4, cpu_rdata = 0x1234.
- CPU write then read: write 0xBEEF to 0x00010, then read 0x00010 -> WE low exactly WAIT_CYC+1 cycles, readback 0xBEEF, cpu_rdata unchanged by the write.
- Tie after reset: cpu_req and dbg_req rise together, both held -> CPU is acked first, DBG next, then CPU again. Grants alternate with no starvation.
- WAIT_CYC = 3: single dbg read -> dbg_ack in cycle 6; a 0xA5A5 pattern is captured into dbg_rdata.
- Protocol check: cpu_req dropped in SETUP -> access completes, cpu_ack still pulses. Assertions confirm OE and WE never both 0, and exactly one ack per grant.
